// File: rtl/idac_pkg.sv
// idac_pkg: shared iDAC constants, responder state encoding and code types.
package idac_pkg;
    localparam int IdacTrigger2drDelayCc = 3;
    localparam int IdacCurrentWidth      = 8;
    localparam int IdacCalibrationWidth  = 5;
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DONE   = 2'd2
    } idac_resp_state_e;
    typedef logic [IdacCurrentWidth-1:0]     idac_curr_t;
    typedef logic [IdacCalibrationWidth-1:0] idac_cal_t;
endpackage

// File: rtl/idac_settle_counter.sv
// idac_settle_counter: loadable down-counter timing the analog settle interval.
//   clk_i, rst_i : clock, synchronous active-high reset
//   clr_i        : forces the count to zero
//   load_i       : loads load_val_i (wins over dec_i)
//   dec_i        : decrements while non-zero
//   zero_o       : the count will be zero after this edge
module idac_settle_counter #(
    parameter int W = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);
    logic [W-1:0] cnt_q, cnt_d;
    always_comb begin
        cnt_d = clr_i ? '0 :
                load_i ? load_val_i :
                (dec_i && cnt_q != '0) ? cnt_q - W'(1) : cnt_q;
    end
    // Looking at the next value lets the FSM reach DONE on the edge the count expires.
    assign zero_o = (cnt_d == '0);
    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
endmodule

// File: rtl/idac_trigger_responder.sv
// idac_trigger_responder: iDAC responder side of the trigger/dr handshake.
//   clk_i, rst_i           : clock, synchronous active-high reset
//   en_i                   : enable; low aborts, zeroes codes, keeps overrun
//   trigger_i              : request strobe, sampled each rising edge
//   current_i, calib_i     : codes captured on an accepted trigger
//   clear_i                : clears overrun_o (a same-cycle drop wins)
//   dr_o, busy_o           : data-ready pulse, conversion in progress
//   overrun_o              : sticky dropped-trigger flag
//   idac_curr_o/cal_o/en_o : registered drive to the analog macro
// Build option IDAC_TRIG_QUEUE_EN adds a one-deep buffer for triggers arriving in SETTLE.
module idac_trigger_responder
    import idac_pkg::*;
#(
    parameter int DelayCc = IdacTrigger2drDelayCc,
    parameter int CurrW   = IdacCurrentWidth,
    parameter int CalW    = IdacCalibrationWidth
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             trigger_i,
    input  logic [CurrW-1:0] current_i,
    input  logic [CalW-1:0]  calib_i,
    input  logic             clear_i,
    output logic             dr_o,
    output logic             busy_o,
    output logic             overrun_o,
    output logic [CurrW-1:0] idac_curr_o,
    output logic [CalW-1:0]  idac_cal_o,
    output logic             idac_en_o
);
    localparam int CntW = $clog2(DelayCc);
    localparam logic [CntW-1:0] LoadVal = CntW'(DelayCc - 1);
    idac_resp_state_e state_q, state_d;
    logic [CurrW-1:0] curr_q, curr_d, src_curr;
    logic [CalW-1:0]  cal_q, cal_d, src_cal;
    logic             overrun_q, overrun_d, en_q;
    logic             in_idle, in_settle, in_done, trig, accept, drop, cnt_zero;
    assign in_idle   = (state_q == IDLE);
    assign in_settle = (state_q == SETTLE);
    assign in_done   = (state_q == DONE);
    assign trig      = trigger_i & en_i;
`ifdef IDAC_TRIG_QUEUE_EN
    logic             pend_v_q, pend_v_d, take_pend, store;
    logic [CurrW-1:0] pend_curr_q, pend_curr_d;
    logic [CalW-1:0]  pend_cal_q, pend_cal_d;
    // A buffered request is replayed in DONE as if it arrived then; a fresh
    // trigger in that same cycle refills the slot being emptied.
    always_comb begin
        take_pend   = en_i & in_done & pend_v_q;
        accept      = take_pend | (trig & (in_idle | in_done));
        store       = trig & ((in_settle & ~pend_v_q) | take_pend);
        drop        = trig & in_settle & pend_v_q;
        src_curr    = take_pend ? pend_curr_q : current_i;
        src_cal     = take_pend ? pend_cal_q : calib_i;
        pend_v_d    = !en_i ? 1'b0 : store ? 1'b1 : take_pend ? 1'b0 : pend_v_q;
        pend_curr_d = store ? current_i : pend_curr_q;
        pend_cal_d  = store ? calib_i : pend_cal_q;
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pend_v_q    <= 1'b0;
            pend_curr_q <= '0;
            pend_cal_q  <= '0;
        end else begin
            pend_v_q    <= pend_v_d;
            pend_curr_q <= pend_curr_d;
            pend_cal_q  <= pend_cal_d;
        end
    end
`else
    always_comb begin
        accept   = trig & (in_idle | in_done);
        drop     = trig & in_settle;
        src_curr = current_i;
        src_cal  = calib_i;
    end
`endif
    idac_settle_counter #(.W(CntW)) u_cnt (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clr_i      (~en_i),
        .load_i     (accept),
        .load_val_i (LoadVal),
        .dec_i      (in_settle),
        .zero_o     (cnt_zero)
    );
    always_comb begin
        state_d   = !en_i ? IDLE :
                    accept ? SETTLE :
                    (in_settle & cnt_zero) ? DONE :
                    in_settle ? SETTLE : IDLE;
        curr_d    = !en_i ? '0 : accept ? src_curr : curr_q;
        cal_d     = !en_i ? '0 : accept ? src_cal : cal_q;
        overrun_d = drop | (overrun_q & ~clear_i);
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            curr_q    <= '0;
            cal_q     <= '0;
            overrun_q <= 1'b0;
            en_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            curr_q    <= curr_d;
            cal_q     <= cal_d;
            overrun_q <= overrun_d;
            en_q      <= en_i;
        end
    end
    assign dr_o        = in_done;
    assign busy_o      = in_settle;
    assign overrun_o   = overrun_q;
    assign idac_curr_o = curr_q;
    assign idac_cal_o  = cal_q;
    assign idac_en_o   = en_q;
endmodule

// File: tb/tb_idac_trigger_responder.sv
// tb_idac_trigger_responder: scoreboard bench for the iDAC trigger responder.
module tb_idac_trigger_responder;
    localparam int D = 3;
    logic       clk = 1'b0;
    logic       rst_i, en_i, trigger_i, clear_i;
    logic [7:0] current_i;
    logic [4:0] calib_i;
    logic       dr_o, busy_o, overrun_o, idac_en_o;
    logic [7:0] idac_curr_o;
    logic [4:0] idac_cal_o;
    typedef struct {
        int         cyc;
        logic [7:0] cur;
        logic [4:0] cal;
    } exp_t;
    exp_t sb[$];
    int cyc = 0;
    int n_chk = 0;
    int n_pass = 0;
    int t;

    idac_trigger_responder dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .en_i        (en_i),
        .trigger_i   (trigger_i),
        .current_i   (current_i),
        .calib_i     (calib_i),
        .clear_i     (clear_i),
        .dr_o        (dr_o),
        .busy_o      (busy_o),
        .overrun_o   (overrun_o),
        .idac_curr_o (idac_curr_o),
        .idac_cal_o  (idac_cal_o),
        .idac_en_o   (idac_en_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic fire(input logic [7:0] c, input logic [4:0] a, input bit acc);
        trigger_i = 1'b1;
        current_i = c;
        calib_i   = a;
        if (acc) sb.push_back('{cyc + D, c, a});
        @(negedge clk);
        trigger_i = 1'b0;
    endtask

    always @(negedge clk) begin
        if (dr_o) begin
            if (sb.size() == 0) chk("dr_unexpected", dr_o, 0);
            else begin
                exp_t e;
                e = sb.pop_front();
                chk("dr_cycle", cyc, e.cyc);
                chk("dr_curr", idac_curr_o, e.cur);
                chk("dr_cal", idac_cal_o, e.cal);
            end
        end
    end

    initial begin
        rst_i = 1'b1; en_i = 1'b1; trigger_i = 1'b0; clear_i = 1'b0;
        current_i = '0; calib_i = '0;
        repeat (3) @(negedge clk);
        chk("rst_dr", dr_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_ovr", overrun_o, 0);
        chk("rst_curr", idac_curr_o, 0);
        chk("rst_cal", idac_cal_o, 0);
        chk("rst_en", idac_en_o, 0);
        rst_i = 1'b0;
        @(negedge clk);
        chk("idac_en_up", idac_en_o, 1);
        repeat (4) @(negedge clk);
        // single conversion, then a back-to-back trigger in the dr cycle
        fire(8'hA5, 5'h0C, 1);
        chk("t1_curr", idac_curr_o, 8'hA5);
        chk("t1_cal", idac_cal_o, 5'h0C);
        chk("t1_busy1", busy_o, 1);
        @(negedge clk);
        chk("t1_busy2", busy_o, 1);
        @(negedge clk);
        chk("t1_busy3", busy_o, 0);
        chk("t1_dr", dr_o, 1);
        fire(8'h3C, 5'h01, 1);
        chk("b2b_busy", busy_o, 1);
        chk("b2b_curr", idac_curr_o, 8'h3C);
        repeat (5) @(negedge clk);
        // trigger during SETTLE
        t = cyc;
        fire(8'hA5, 5'h0C, 1);
        fire(8'hFF, 5'h1F, 0);
`ifdef IDAC_TRIG_QUEUE_EN
        sb.push_back('{t + 2 * D, 8'hFF, 5'h1F});
        chk("drop_ovr", overrun_o, 0);
`else
        chk("drop_ovr", overrun_o, 1);
`endif
        chk("drop_curr_hold", idac_curr_o, 8'hA5);
        repeat (2) @(negedge clk);
`ifdef IDAC_TRIG_QUEUE_EN
        chk("q_curr", idac_curr_o, 8'hFF);
`else
        chk("q_curr", idac_curr_o, 8'hA5);
`endif
        repeat (4) @(negedge clk);
        clear_i = 1'b1;
        @(negedge clk);
        clear_i = 1'b0;
        chk("clr_ovr", overrun_o, 0);
        // drop coinciding with clear: set wins
        t = cyc;
        fire(8'h12, 5'h03, 1);
        fire(8'h34, 5'h05, 0);
`ifdef IDAC_TRIG_QUEUE_EN
        sb.push_back('{t + 2 * D, 8'h34, 5'h05});
`endif
        clear_i = 1'b1;
        fire(8'h56, 5'h07, 0);
        clear_i = 1'b0;
        chk("set_wins", overrun_o, 1);
        repeat (6) @(negedge clk);
        // enable dropped mid-conversion; overrun retained
        fire(8'h11, 5'h02, 0);
        @(negedge clk);
        en_i = 1'b0;
        @(negedge clk);
        chk("en_curr0", idac_curr_o, 0);
        chk("en_cal0", idac_cal_o, 0);
        chk("en_idac_en", idac_en_o, 0);
        chk("en_busy", busy_o, 0);
        chk("en_ovr_keep", overrun_o, 1);
        en_i = 1'b1;
        @(negedge clk);
        fire(8'h22, 5'h03, 1);
        repeat (4) @(negedge clk);
        clear_i = 1'b1;
        @(negedge clk);
        clear_i = 1'b0;
        chk("clr2_ovr", overrun_o, 0);
        // trigger with en low is ignored
        en_i = 1'b0;
        @(negedge clk);
        fire(8'h77, 5'h07, 0);
        chk("dis_busy", busy_o, 0);
        chk("dis_curr", idac_curr_o, 0);
        chk("dis_ovr", overrun_o, 0);
        en_i = 1'b1;
        repeat (3) @(negedge clk);
        // reset mid-conversion with trigger held
        trigger_i = 1'b1; current_i = 8'h44; calib_i = 5'h04;
        @(negedge clk);
        @(negedge clk);
`ifdef IDAC_TRIG_QUEUE_EN
        chk("held_ovr", overrun_o, 0);
`else
        chk("held_ovr", overrun_o, 1);
`endif
        rst_i = 1'b1;
        @(negedge clk);
        trigger_i = 1'b0;
        chk("mrst_dr", dr_o, 0);
        chk("mrst_busy", busy_o, 0);
        chk("mrst_curr", idac_curr_o, 0);
        chk("mrst_cal", idac_cal_o, 0);
        chk("mrst_ovr", overrun_o, 0);
        chk("mrst_en", idac_en_o, 0);
        rst_i = 1'b0;
        repeat (10) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
